// File: rtl/rr_enc_arbiter_4_pkg.sv
// ============================================================================
// arb_pkg : shared constants, state type and helpers for rr_enc_arbiter_4
// Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_enc_arbiter_4_if.sv
// ============================================================================
// rr_enc_arbiter_4_if : request/grant bundle between agents and the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface rr_enc_arbiter_4_if;
   import arb_pkg::*;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );

endinterface

`default_nettype wire

// File: rtl/rr_enc_arbiter_4_pick.sv
// ============================================================================
// rr_pick_4 : combinational round-robin picker, first set bit from ptr upward
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick_4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] pick
);

   logic [NREQ-1:0]  rot;
   logic [IDX_W-1:0] off;

   // Rotate so the pointer position lands on bit 0.
   always_comb begin
      rot = req;
      case (ptr)
         2'd0:    rot = req;
         2'd1:    rot = {req[0],   req[3:1]};
         2'd2:    rot = {req[1:0], req[3:2]};
         2'd3:    rot = {req[2:0], req[3]};
         default: rot = req;
      endcase
   end

   always_comb begin
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = k[IDX_W-1:0];
      end
   end

   assign any  = |req;
   assign pick = ptr + off;

endmodule

`default_nettype wire

// File: rtl/rr_enc_arbiter_4.sv
// ============================================================================
// rr_enc_arbiter_4 : 4-way round-robin arbiter, registered one-hot + encoded
//                    grant, with a hold-time watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_enc_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = $clog2(MAX_HOLD)
)(
   input  logic                 clk,
   input  logic                 rst,
   rr_enc_arbiter_4_if.slave    bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state_q,   state_d;
   logic [IDX_W-1:0] ptr_q,     ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [NREQ-1:0]  gnt_q,     gnt_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;

   rr_pick_4 u_pick (
      .req  (bus.req),
      .ptr  (ptr_q),
      .any  (pick_any),
      .pick (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      timeout_d  = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            if (pick_any) begin
               gnt_d      = onehot4(pick_idx);
               idx_d      = pick_idx;
               valid_d    = 1'b1;
               hold_cnt_d = '0;
               state_d    = GRANT;
            end
         end

         GRANT: begin
            // Release wins over the watchdog when both land on the same cycle.
            if (!bus.req[idx_q] || (hold_cnt_q == HOLD_LAST)) begin
               timeout_d  = bus.req[idx_q];
               gnt_d      = '0;
               idx_d      = '0;
               valid_d    = 1'b0;
               hold_cnt_d = '0;
               ptr_d      = idx_q + IDX_W'(1);
               state_d    = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = timeout_q;

endmodule

`default_nettype wire

// File: doc/rr_enc_arbiter_4.md
Name: rr_enc_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- Outputs a registered one-hot grant plus the 2-bit encoded owner index: req bit0 -> 00, bit1 -> 01, bit2 -> 10, bit3 -> 11.
- Holds a grant while the owner keeps requesting, with a hold-time watchdog that forces release.
- Sits between requesting agents and the shared datapath that the encoded index steers.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; legal range 2..256.
- CNT_W, $clog2(MAX_HOLD), hold-counter width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  request vector; req[k] is held high while agent k wants or uses the resource.
- gnt  out  4  registered one-hot grant; 0000 when idle.
- gnt_idx  out  2  encoded index of the current owner; 00 when idle.
- gnt_valid  out  1  high while a grant is active; equals |gnt.
- timeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (rst sampled high at a posedge) sets the following, regardless of req or state, including mid-grant:
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - hold_cnt=0, ptr=00, state=IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ... mod 4.
  - Next cycle: gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled in IDLE to gnt visible is one cycle.
  - If req==0, stay in IDLE with outputs at 0.
- GRANT, normal release:
  - When req[owner]==0, the next cycle has gnt=0, gnt_valid=0, gnt_idx=00, ptr=owner+1 mod 4, state=IDLE.
  - This gives exactly one idle bubble between consecutive grants.
- GRANT, hold:
  - When req[owner]==1 and hold_cnt<MAX_HOLD-1, hold_cnt increments and outputs are unchanged.
  - Requests from other agents never preempt the owner.
- GRANT, watchdog:
  - When req[owner]==1 and hold_cnt==MAX_HOLD-1, the next cycle has grant outputs cleared, timeout=1 for one cycle, ptr=owner+1 mod 4, state=IDLE.
  - The grant is therefore asserted for exactly MAX_HOLD cycles.
  - The timed-out agent may be re-granted later by normal rotation; it is not blacklisted.
- Simultaneous release and watchdog (req[owner] drops on the terminal count cycle): treated as a normal release, timeout stays 0.
- Pointer wrap: owner 3 sets ptr to 00.
- Changes on non-owner req bits during GRANT are ignored until the next IDLE evaluation.
- A glitching req that is high only in the IDLE evaluation cycle still receives a one-cycle-minimum grant.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx is always consistent with gnt.
  - timeout is never high in two consecutive cycles.
  - All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package arb_pkg holds:
  - NREQ=4, IDX_W=2.
  - Enum arb_state_t {IDLE, GRANT}.
  - Function onehot4(idx) returning a 4-bit one-hot vector.
- Sub-module rr_pick_4 (combinational): inputs req[3:0] and ptr[1:0]; outputs any and pick[1:0].
  - Implementation: rotate req right by ptr, priority-encode from the lowest bit, add ptr mod 4.
  - Unit-testable exhaustively with 64 input combinations.

Test Plan:
- Reset and idle: hold rst for 2 cycles with req=1111, then release rst with req=0000 -> all outputs 0 for 5 cycles.
- Single requester, normal release: req=0100 for 3 cycles, then 0000 -> gnt=0100 and gnt_idx=10 one cycle after the first sample; drop one cycle after req falls; next grant search starts at index 3.
- Round-robin fairness: req=1111 held, each owner drops its bit after 2 granted cycles then re-raises it -> grant order idx 00, 01, 10, 11, 00 with a 1-cycle bubble between grants.
- Watchdog (MAX_HOLD=4): req=0010 held constantly -> gnt=0010 for exactly 4 cycles, timeout pulses once, then one idle cycle, then re-grant of idx 01 (the only requester).
- Simultaneous events:
  - With MAX_HOLD=4, owner drops req on the 4th hold cycle -> timeout stays 0, normal release.
  - Apply rst while gnt=1000 -> next cycle all outputs 0 and ptr=00, so req=1001 then grants idx 00.
- Pointer wrap: owner 3 releases with req=1001 -> next grant is idx 00 (bit0), not 11.
